ctrl_pipe_unit: RTL and testbench
=================================

CTRL_PIPE_UNIT -- requirements
Module: ctrl_pipe_unit

Interface
REQ-001 SHALL have parameter EN_M, default 1: 1 decodes RV32M (opcode 0110011 with funct7=0000001); 0 flags those as illegal.
REQ-002 SHALL have parameter DIV_LATENCY, default 4, legal range 2..16: EX-stage occupancy in cycles of DIV/DIVU/REM/REMU.
REQ-003 SHALL have localparam ALU_CTRL_W = EN_M ? 5 : 4.
REQ-004 SHALL have ports clk_i (input, 1, clock) and rst_i (input, 1, reset); one clock, reset asynchronous and active-high.
REQ-005 SHALL have ports valid_i (input, 1, decode slot holds an instruction), op_i (input, 7, opcode), funct3_i (input, 3), funct7_i (input, 7).
REQ-006 SHALL have ports stall_i (input, 1, hazard hold of the EX register) and flush_i (input, 1, kill the EX register).
REQ-007 SHALL have port imm_src_o (output, 3, combinational, decode-stage immediate select).
REQ-008 SHALL have registered EX outputs valid_ex_o, jump_ex_o, branch_ex_o, jalr_ex_o, mem_write_ex_o, alu_src_ex_o, reg_write_ex_o, byte_address_ex_o (each 1); result_src_ex_o (2); alu_control_ex_o (ALU_CTRL_W); illegal_ex_o (1).
REQ-009 SHALL have port busy_o (output, 1, multicycle op occupies EX; upstream must hold).

Function
REQ-010 Decode SHALL be combinational: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111; any other opcode is illegal.
REQ-011 imm_src SHALL be I=000, S=001, B=010, J=011, U=100; R-type 000.
REQ-012 result_src SHALL be 00 ALU, 01 memory (loads), 10 PC+4 (jal/jalr); byte_address asserted for funct3=000 or 100 on loads/stores.
REQ-013 alu_control SHALL be ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, SLTU 1001, PASS_B 1010 (lui); SUB only for R-type funct7[5]=1; SRA for funct7[5]=1 on shifts; loads/stores/jalr/auipc use ADD, branches SUB.
REQ-014 With EN_M=1, M ops SHALL drive alu_control = {1'b1, 1'b0, funct3}; base ops zero-extend to 5 bits.
REQ-015 FSM states SHALL be IDLE and MD_BUSY.
REQ-016 In IDLE, priority SHALL be flush_i > stall_i > capture: flush loads a bubble (valid and all enables 0), stall holds the register, otherwise the register loads decoded controls with valid_ex_o=valid_i.
REQ-017 A captured valid DIV/DIVU/REM/REMU (funct3[2]=1) SHALL move to MD_BUSY, load counter with DIV_LATENCY-1, and assert busy_o combinationally from that state.
REQ-018 In MD_BUSY the EX register SHALL hold, the counter decrements each cycle, and at counter=1 the FSM returns to IDLE, giving exactly DIV_LATENCY cycles of EX occupancy with busy_o high for DIV_LATENCY-1 of them.
REQ-019 flush_i in MD_BUSY SHALL abort: return to IDLE, clear counter, load a bubble; stall_i in MD_BUSY has no effect.
REQ-020 MUL variants (funct3[2]=0) SHALL be single-cycle and never enter MD_BUSY.
REQ-021 An illegal valid instruction SHALL capture with illegal_ex_o=1, valid_ex_o=1, reg_write/mem_write/jump/branch/jalr all 0.
REQ-022 valid_i=0 SHALL capture a bubble with illegal_ex_o=0.

Reset
REQ-023 rst_i SHALL asynchronously force IDLE, counter 0, busy_o 0, and every EX output to 0; imm_src_o remains combinational.
REQ-024 Reset asserted mid-MD_BUSY SHALL discard the operation; after release the first valid capture occurs on the first rising edge.

Structure
REQ-025 Opcode constants, ALU control encodings, imm_src/result_src encodings and the FSM state enum SHALL live in shared package ctrl_pkg.
REQ-026 Combinational decode SHALL be one sub-module, ctrl_decoder, parametrised by EN_M; the FSM, counter and EX register sit in ctrl_pipe_unit.

Verification
REQ-027 add (0110011, f3 000, f7 0000000) valid -> next cycle valid_ex=1, reg_write=1, alu_control=00000, result_src=00.
REQ-028 sw (0100011, f3 010) with stall_i=1 one cycle -> EX holds prior contents, captures sw after stall drops: mem_write=1, imm_src=001.
REQ-029 div (f7 0000001, f3 100), DIV_LATENCY=4 -> alu_control=10100, busy_o high 3 cycles, next instruction captured on cycle 5.
REQ-030 div then flush_i on 2nd busy cycle -> busy_o drops next cycle, valid_ex=0.
REQ-031 EN_M=0, mul (f7 0000001, f3 000) -> illegal_ex=1, reg_write=0; opcode 1111111 -> illegal_ex=1.
REQ-032 rst_i pulsed asynchronously mid-MD_BUSY -> all EX outputs and busy_o 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline unit: opcode constants, ALU
// control encodings, immediate/result selectors, the EX control bundle and
// the multicycle FSM state type. Exports no ports; imported by the decoder
// and by ctrl_pipe_unit.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_SLL    = 4'b0110;
    localparam logic [3:0] ALU_SRL    = 4'b0111;
    localparam logic [3:0] ALU_SRA    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_PASS_B = 4'b1010;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_e;

    // Width-independent part of the EX register (alu_control is carried
    // separately because its width depends on EN_M).
    typedef struct packed {
        logic       valid;
        logic       jump;
        logic       branch;
        logic       jalr;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       byte_address;
        logic [1:0] result_src;
        logic       illegal;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE = '0;

    // Byte-sized accesses are LB/LBU and SB.
    function automatic logic is_byte_access(input logic [2:0] funct3);
        return (funct3 == 3'b000) || (funct3 == 3'b100);
    endfunction

    // Base-ISA ALU op from funct3; sub_sel/sra_sel pick the funct7[5] variants.
    function automatic logic [3:0] base_alu_op(input logic [2:0] funct3,
                                               input logic       sub_sel,
                                               input logic       sra_sel);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = sra_sel ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational RV32I(+M) control decoder.
// Inputs : op_i, funct3_i, funct7_i (instruction fields)
// Outputs: ctrl_o (EX control bundle, valid bit left 0), alu_control_o,
//          imm_src_o (immediate format), is_div_o (multicycle DIV/REM op)
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int  EN_M       = 1,
    localparam int ALU_CTRL_W = (EN_M != 32'sd0) ? 5 : 4
) (
    input  logic [6:0]            op_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    output ex_ctrl_t              ctrl_o,
    output logic [ALU_CTRL_W-1:0] alu_control_o,
    output logic [2:0]            imm_src_o,
    output logic                  is_div_o
);

    localparam bit M_ON = (EN_M != 32'sd0);

    logic alt_s;
    logic is_md_s;

    assign alt_s   = funct7_i[5];
    assign is_md_s = (funct7_i == F7_MULDIV);

    // Opcode-driven control decode; unknown opcodes flag illegal with every enable low.
    always_comb begin
        ctrl_o        = EX_BUBBLE;
        alu_control_o = ALU_CTRL_W'(ALU_ADD);
        imm_src_o     = IMM_I;
        is_div_o      = 1'b0;
        case (op_i)
            OP_R: begin
                if (is_md_s) begin
                    if (M_ON) begin
                        ctrl_o.reg_write = 1'b1;
                        alu_control_o    = ALU_CTRL_W'({2'b10, funct3_i});
                        is_div_o         = funct3_i[2];
                    end else begin
                        ctrl_o.illegal = 1'b1;
                    end
                end else begin
                    ctrl_o.reg_write = 1'b1;
                    alu_control_o    = ALU_CTRL_W'(base_alu_op(funct3_i, alt_s, alt_s));
                end
            end
            OP_I_ALU: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                // funct7[5] is an immediate bit for ADDI, so never SUB here.
                alu_control_o    = ALU_CTRL_W'(base_alu_op(funct3_i, 1'b0, alt_s));
            end
            OP_LOAD: begin
                ctrl_o.reg_write    = 1'b1;
                ctrl_o.alu_src      = 1'b1;
                ctrl_o.result_src   = RES_MEM;
                ctrl_o.byte_address = is_byte_access(funct3_i);
            end
            OP_STORE: begin
                ctrl_o.mem_write    = 1'b1;
                ctrl_o.alu_src      = 1'b1;
                ctrl_o.byte_address = is_byte_access(funct3_i);
                imm_src_o           = IMM_S;
            end
            OP_BRANCH: begin
                ctrl_o.branch = 1'b1;
                alu_control_o = ALU_CTRL_W'(ALU_SUB);
                imm_src_o     = IMM_B;
            end
            OP_JAL: begin
                ctrl_o.jump       = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.result_src = RES_PC4;
                imm_src_o         = IMM_J;
            end
            OP_JALR: begin
                ctrl_o.jalr       = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_PC4;
            end
            OP_LUI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                alu_control_o    = ALU_CTRL_W'(ALU_PASS_B);
                imm_src_o        = IMM_U;
            end
            OP_AUIPC: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                imm_src_o        = IMM_U;
            end
            default: begin
                ctrl_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Control pipeline unit: decodes the instruction in the decode slot and
// registers the controls into the EX stage, holding EX for DIV/REM ops.
// Inputs : clk_i, rst_i (async, active-high), valid_i, op_i, funct3_i,
//          funct7_i, stall_i (hold EX), flush_i (kill EX)
// Outputs: imm_src_o (combinational), *_ex_o registered EX controls,
//          busy_o (EX occupied by a multicycle op; upstream must hold)
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int  EN_M        = 1,
    parameter int  DIV_LATENCY = 4,
    localparam int ALU_CTRL_W  = (EN_M != 32'sd0) ? 5 : 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [6:0]            op_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic [2:0]            imm_src_o,
    output logic                  valid_ex_o,
    output logic                  jump_ex_o,
    output logic                  branch_ex_o,
    output logic                  jalr_ex_o,
    output logic                  mem_write_ex_o,
    output logic                  alu_src_ex_o,
    output logic                  reg_write_ex_o,
    output logic                  byte_address_ex_o,
    output logic [1:0]            result_src_ex_o,
    output logic [ALU_CTRL_W-1:0] alu_control_ex_o,
    output logic                  illegal_ex_o,
    output logic                  busy_o
);

    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ex_ctrl_t              dec_ctrl_s;
    logic [ALU_CTRL_W-1:0] dec_alu_s;
    logic                  dec_is_div_s;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    ex_ctrl_t              ex_q, ex_d;
    logic [ALU_CTRL_W-1:0] alu_q, alu_d;

    ctrl_decoder #(
        .EN_M (EN_M)
    ) u_dec (
        .op_i          (op_i),
        .funct3_i      (funct3_i),
        .funct7_i      (funct7_i),
        .ctrl_o        (dec_ctrl_s),
        .alu_control_o (dec_alu_s),
        .imm_src_o     (imm_src_o),
        .is_div_o      (dec_is_div_s)
    );

    // Next-state, occupancy counter and EX register load selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_d    = ex_q;
        alu_d   = alu_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    ex_d  = EX_BUBBLE;
                    alu_d = '0;
                    cnt_d = '0;
                end else if (stall_i) begin
                    ex_d  = ex_q;
                    alu_d = alu_q;
                end else if (valid_i) begin
                    ex_d       = dec_ctrl_s;
                    ex_d.valid = 1'b1;
                    alu_d      = dec_alu_s;
                    if (dec_is_div_s) begin
                        state_d = ST_MD_BUSY;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    ex_d  = EX_BUBBLE;
                    alu_d = '0;
                    cnt_d = '0;
                end
            end
            ST_MD_BUSY: begin
                // EX holds the divide; stall_i is irrelevant while occupied.
                if (flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ex_d    = EX_BUBBLE;
                    alu_d   = '0;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ex_d    = EX_BUBBLE;
                alu_d   = '0;
            end
        endcase
    end

    // State, counter and EX register flops with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ex_q    <= EX_BUBBLE;
            alu_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            alu_q   <= alu_d;
        end
    end

    assign busy_o            = (state_q == ST_MD_BUSY);
    assign valid_ex_o        = ex_q.valid;
    assign jump_ex_o         = ex_q.jump;
    assign branch_ex_o       = ex_q.branch;
    assign jalr_ex_o         = ex_q.jalr;
    assign mem_write_ex_o    = ex_q.mem_write;
    assign alu_src_ex_o      = ex_q.alu_src;
    assign reg_write_ex_o    = ex_q.reg_write;
    assign byte_address_ex_o = ex_q.byte_address;
    assign result_src_ex_o   = ex_q.result_src;
    assign illegal_ex_o      = ex_q.illegal;
    assign alu_control_ex_o  = alu_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit. Three instances share the stimulus:
// d0 EN_M=1/DIV_LATENCY=4, d1 EN_M=0/DIV_LATENCY=4, d2 EN_M=1/DIV_LATENCY=2.
module tb_ctrl_pipe_unit;

    typedef struct packed {
        logic       valid;
        logic       jump;
        logic       branch;
        logic       jalr;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       byte_address;
        logic [1:0] result_src;
        logic [4:0] alu;
        logic       illegal;
        logic       busy;
    } obs_t;
    typedef obs_t [2:0] trio_t;

    localparam logic [6:0] R = 7'b0110011, IA = 7'b0010011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [6:0] op = 7'd0, f7 = 7'd0;
    logic [2:0] f3 = 3'd0;

    logic [2:0] imm_0, imm_1, imm_2;
    logic v_0, j_0, b_0, jr_0, mw_0, as_0, rw_0, ba_0, il_0, bz_0;
    logic v_1, j_1, b_1, jr_1, mw_1, as_1, rw_1, ba_1, il_1, bz_1;
    logic v_2, j_2, b_2, jr_2, mw_2, as_2, rw_2, ba_2, il_2, bz_2;
    logic [1:0] rs_0, rs_1, rs_2;
    logic [4:0] alu_0, alu_2;
    logic [3:0] alu_1;

    obs_t obs_w [3];
    assign obs_w[0] = {v_0, j_0, b_0, jr_0, mw_0, as_0, rw_0, ba_0, rs_0, alu_0, il_0, bz_0};
    assign obs_w[1] = {v_1, j_1, b_1, jr_1, mw_1, as_1, rw_1, ba_1, rs_1, {1'b0, alu_1}, il_1, bz_1};
    assign obs_w[2] = {v_2, j_2, b_2, jr_2, mw_2, as_2, rw_2, ba_2, rs_2, alu_2, il_2, bz_2};

    always #5 clk = ~clk;

    ctrl_pipe_unit #(.EN_M(1), .DIV_LATENCY(4)) u_d0 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .funct3_i(f3), .funct7_i(f7),
        .stall_i(stall), .flush_i(flush), .imm_src_o(imm_0), .valid_ex_o(v_0), .jump_ex_o(j_0),
        .branch_ex_o(b_0), .jalr_ex_o(jr_0), .mem_write_ex_o(mw_0), .alu_src_ex_o(as_0),
        .reg_write_ex_o(rw_0), .byte_address_ex_o(ba_0), .result_src_ex_o(rs_0),
        .alu_control_ex_o(alu_0), .illegal_ex_o(il_0), .busy_o(bz_0));
    ctrl_pipe_unit #(.EN_M(0), .DIV_LATENCY(4)) u_d1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .funct3_i(f3), .funct7_i(f7),
        .stall_i(stall), .flush_i(flush), .imm_src_o(imm_1), .valid_ex_o(v_1), .jump_ex_o(j_1),
        .branch_ex_o(b_1), .jalr_ex_o(jr_1), .mem_write_ex_o(mw_1), .alu_src_ex_o(as_1),
        .reg_write_ex_o(rw_1), .byte_address_ex_o(ba_1), .result_src_ex_o(rs_1),
        .alu_control_ex_o(alu_1), .illegal_ex_o(il_1), .busy_o(bz_1));
    ctrl_pipe_unit #(.EN_M(1), .DIV_LATENCY(2)) u_d2 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .funct3_i(f3), .funct7_i(f7),
        .stall_i(stall), .flush_i(flush), .imm_src_o(imm_2), .valid_ex_o(v_2), .jump_ex_o(j_2),
        .branch_ex_o(b_2), .jalr_ex_o(jr_2), .mem_write_ex_o(mw_2), .alu_src_ex_o(as_2),
        .reg_write_ex_o(rw_2), .byte_address_ex_o(ba_2), .result_src_ex_o(rs_2),
        .alu_control_ex_o(alu_2), .illegal_ex_o(il_2), .busy_o(bz_2));

    int en_cfg  [3] = '{1, 0, 1};
    int lat_cfg [3] = '{4, 4, 2};
    logic [4:0] alu_by_f3 [8] = '{5'd0, 5'd6, 5'd5, 5'd9, 5'd4, 5'd7, 5'd3, 5'd2};
    logic [6:0] op_tbl [9] = '{R, IA, LD, ST, BR, JAL, JALR, LUI, AUIPC};

    // Reference state: expected EX contents and the edge index at which each
    // instance's EX stage becomes free again.
    obs_t  ex_m [3];
    int    free_edge [3];
    int    edge_n = 0;
    trio_t exp_q [$];
    int    total = 0, bad = 0;

    task automatic check(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s d%0d: got=%h expected=%h at %0t", name, d, got, exp, $time);
        end
    endtask

    function automatic obs_t ref_decode(input logic [6:0] o, input logic [2:0] a,
                                        input logic [6:0] s7, input int en);
        obs_t e = '0;
        e.valid = 1'b1;
        case (o)
            R: begin
                if (s7 == 7'h01) begin
                    if (en != 0) begin e.reg_write = 1'b1; e.alu = {2'b10, a}; end
                    else e.illegal = 1'b1;
                end else begin
                    e.reg_write = 1'b1;
                    e.alu = alu_by_f3[a];
                    if (s7[5] && a == 3'd0) e.alu = 5'd1;
                    if (s7[5] && a == 3'd5) e.alu = 5'd8;
                end
            end
            IA: begin
                e.reg_write = 1'b1; e.alu_src = 1'b1; e.alu = alu_by_f3[a];
                if (s7[5] && a == 3'd5) e.alu = 5'd8;
            end
            LD: begin
                e.reg_write = 1'b1; e.alu_src = 1'b1; e.result_src = 2'b01;
                e.byte_address = (a == 3'd0 || a == 3'd4);
            end
            ST: begin
                e.mem_write = 1'b1; e.alu_src = 1'b1;
                e.byte_address = (a == 3'd0 || a == 3'd4);
            end
            BR:    begin e.branch = 1'b1; e.alu = 5'd1; end
            JAL:   begin e.jump = 1'b1; e.reg_write = 1'b1; e.result_src = 2'b10; end
            JALR:  begin e.jalr = 1'b1; e.reg_write = 1'b1; e.alu_src = 1'b1; e.result_src = 2'b10; end
            LUI:   begin e.reg_write = 1'b1; e.alu_src = 1'b1; e.alu = 5'd10; end
            AUIPC: begin e.reg_write = 1'b1; e.alu_src = 1'b1; end
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [2:0] ref_imm(input logic [6:0] o);
        if (o == ST) return 3'b001;
        if (o == BR) return 3'b010;
        if (o == JAL) return 3'b011;
        if (o == LUI || o == AUIPC) return 3'b100;
        return 3'b000;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            ex_m[d] = '0;
            free_edge[d] = 0;
        end
    endtask

    // Drive one cycle of stimulus, check imm_src, predict EX after the edge.
    task automatic step(input bit v, input logic [6:0] o, input logic [2:0] a,
                        input logic [6:0] s7, input bit st, input bit fl);
        trio_t t;
        @(negedge clk);
        valid = v; op = o; f3 = a; f7 = s7; stall = st; flush = fl;
        #1;
        check("imm_src", 0, 32'(imm_0), 32'(ref_imm(o)));
        check("imm_src", 1, 32'(imm_1), 32'(ref_imm(o)));
        check("imm_src", 2, 32'(imm_2), 32'(ref_imm(o)));
        for (int d = 0; d < 3; d++) begin
            if (edge_n < free_edge[d]) begin
                if (fl) begin ex_m[d] = '0; free_edge[d] = edge_n; end
            end else if (fl) begin
                ex_m[d] = '0;
            end else if (st) begin
                ex_m[d] = ex_m[d];
            end else if (!v) begin
                ex_m[d] = '0;
            end else begin
                ex_m[d] = ref_decode(o, a, s7, en_cfg[d]);
                if (o == R && s7 == 7'h01 && en_cfg[d] != 0 && a[2])
                    free_edge[d] = edge_n + lat_cfg[d];
            end
            t[d] = ex_m[d];
            t[d].busy = (edge_n + 1) < free_edge[d];
        end
        exp_q.push_back(t);
        edge_n++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: after every active edge, compare presented EX state with the scoreboard head.
    initial begin
        trio_t t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                t = exp_q.pop_front();
                for (int d = 0; d < 3; d++) check("ex_regs", d, 32'(obs_w[d]), 32'(t[d]));
            end
        end
    end

    initial begin
        int busy_cnt0, busy_cnt2, cap;
        model_reset();
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) check("reset_state", d, 32'(obs_w[d]), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        // add
        step(1, R, 3'd0, 7'h00, 0, 0);
        check("add_valid", 0, 32'(v_0), 32'd1);
        check("add_regw", 0, 32'(rw_0), 32'd1);
        check("add_alu", 0, 32'(alu_0), 32'd0);
        check("add_res", 0, 32'(rs_0), 32'd0);

        // sw held by stall, then captured
        step(1, ST, 3'd2, 7'h00, 1, 0);
        check("stall_hold_memw", 0, 32'(mw_0), 32'd0);
        check("stall_hold_regw", 0, 32'(rw_0), 32'd1);
        step(1, ST, 3'd2, 7'h00, 0, 0);
        check("sw_memw", 0, 32'(mw_0), 32'd1);
        check("sw_imm", 0, 32'(imm_0), 32'd1);

        // div: occupancy and next capture on cycle 5 (d0), busy 1 cycle on d2
        step(1, R, 3'd4, 7'h01, 0, 0);
        check("div_alu", 0, 32'(alu_0), 32'h14);
        busy_cnt0 = int'(bz_0);
        busy_cnt2 = int'(bz_2);
        cap = -1;
        for (int i = 2; i <= 9 && cap < 0; i++) begin
            step(1, IA, 3'd0, 7'h00, 0, 0);
            busy_cnt0 += int'(bz_0);
            busy_cnt2 += int'(bz_2);
            if (as_0 == 1'b1) cap = i;
        end
        check("div_busy_cycles", 0, 32'(busy_cnt0), 32'd3);
        check("div_busy_cycles", 2, 32'(busy_cnt2), 32'd1);
        check("div_next_capture_cycle", 0, 32'(cap), 32'd5);

        // div then flush on the second busy cycle
        step(1, R, 3'd5, 7'h01, 0, 0);
        step(1, IA, 3'd1, 7'h00, 0, 0);
        step(1, IA, 3'd1, 7'h00, 0, 1);
        check("flush_busy", 0, 32'(bz_0), 32'd0);
        check("flush_valid", 0, 32'(v_0), 32'd0);

        // mul: illegal without M, single-cycle with M
        step(1, R, 3'd0, 7'h01, 0, 0);
        check("mul_noM_illegal", 1, 32'(il_1), 32'd1);
        check("mul_noM_regw", 1, 32'(rw_1), 32'd0);
        check("mul_alu", 0, 32'(alu_0), 32'h10);
        check("mul_busy", 0, 32'(bz_0), 32'd0);
        step(1, 7'h7f, 3'd0, 7'h00, 0, 0);
        check("bad_op_illegal", 0, 32'(il_0), 32'd1);
        check("bad_op_valid", 0, 32'(v_0), 32'd1);
        step(0, 7'h7f, 3'd0, 7'h00, 0, 0);
        check("bubble_illegal", 0, 32'(il_0), 32'd0);

        // async reset in the middle of a divide
        step(1, R, 3'd6, 7'h01, 0, 0);
        step(1, LUI, 3'd0, 7'h00, 0, 0);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) check("async_reset", d, 32'(obs_w[d]), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        step(1, JAL, 3'd0, 7'h00, 0, 0);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            int sel, fsel;
            logic [6:0] o, s7;
            sel = $urandom_range(0, 11);
            o = (sel < 9) ? op_tbl[sel] : 7'($urandom_range(0, 127));
            fsel = $urandom_range(0, 3);
            s7 = (fsel == 0) ? 7'h00 : (fsel == 1) ? 7'h20 : (fsel == 2) ? 7'h01 : 7'($urandom_range(0, 127));
            step($urandom_range(0, 9) != 0, o, 3'($urandom_range(0, 7)), s7,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
        end

        @(negedge clk);
        check("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
